dmem_responder: RTL

//  Responder end of the CPU data-memory port. Accepts one load/store request at a time from the MEM stage.
//  The request is addr, byte-write enables and write data. The block holds it for WAIT_STATES cycles,

---
 rtl/dmem_responder_pkg.sv | 18 +
 rtl/dmem_responder_array.sv | 43 ++++
 rtl/dmem_responder.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/dmem_responder_pkg.sv
// Shared definitions for the data-memory responder.
//
// Contents:
//   state_t    : FSM encoding (IDLE=0, WAIT=1, RESP=2)
//   BYTE_LANES : number of byte write lanes per word
//   DATA_W     : data word width in bits
package dmem_responder_pkg;

    localparam int BYTE_LANES = 4;
    localparam int DATA_W     = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

endpackage

// File: rtl/dmem_responder_array.sv
// Single-port synchronous word array with per-byte write enables.
//
// Ports:
//   clk  : clock, rising edge
//   en   : access enable; dout and the array only change when en=1
//   wea  : byte write enables, bit i -> din[8i+7:8i]
//   idx  : word index
//   din  : write data
//   dout : read data, registered; holds its value while en=0
//
// The read returns the word as it was before this access's write.
// There is no reset: contents and dout power up undefined.
module dmem_array
    import dmem_responder_pkg::*;
#(
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  en,
    input  logic [BYTE_LANES-1:0] wea,
    input  logic [ADDR_WIDTH-1:0] idx,
    input  logic [DATA_W-1:0]     din,
    output logic [DATA_W-1:0]     dout
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_W-1:0] mem [DEPTH];

    // The read and the lane writes share one edge; non-blocking
    // assignment makes dout pick up the old word.
    always_ff @(posedge clk) begin
        if (en) begin
            dout <= mem[idx];
            for (int i = 0; i < BYTE_LANES; i++) begin
                if (wea[i]) begin
                    mem[idx][8*i +: 8] <= din[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// Responder end of the CPU data-memory port.
//
// Accepts one load/store at a time, holds it for WAIT_STATES cycles,
// performs the access on the internal word array and returns the old
// word with a one-cycle resp_valid. stall_req holds the pipeline while
// an access is in flight.
//
// Ports:
//   clk        : clock, rising edge
//   reset      : asynchronous, active-low reset
//   req_en     : request present
//   req_wea    : byte write enables (0 = load)
//   req_addr   : byte address; [1:0] ignored
//   req_wdata  : lane-aligned store data
//   resp_valid : one-cycle pulse when an access completes
//   resp_rdata : word before this access's write (0 when out of range)
//   resp_err   : address above the array range
//   stall_req  : hold MEM and earlier stages
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int ADDR_WIDTH  = 10,
    parameter int WAIT_STATES = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_en,
    input  logic [BYTE_LANES-1:0] req_wea,
    input  logic [31:0]           req_addr,
    input  logic [DATA_W-1:0]     req_wdata,
    output logic                  resp_valid,
    output logic [DATA_W-1:0]     resp_rdata,
    output logic                  resp_err,
    output logic                  stall_req
);

    state_t state;
    state_t next_state;

    logic [3:0]            wait_cnt;
    logic [ADDR_WIDTH-1:0] lat_idx;
    logic [BYTE_LANES-1:0] lat_wea;
    logic [DATA_W-1:0]     lat_wdata;
    logic                  lat_err;
    logic                  rdata_live;

    logic                  req_err;
    logic [ADDR_WIDTH-1:0] acc_idx;
    logic [BYTE_LANES-1:0] acc_wea;
    logic [DATA_W-1:0]     acc_wdata;
    logic                  acc_err;
    logic                  access_fire;
    logic [DATA_W-1:0]     arr_dout;
    logic                  unused_addr_bits;

    assign unused_addr_bits = ^req_addr[1:0];

    assign req_err = (req_addr >> (ADDR_WIDTH + 2)) != 32'd0;

    // With no wait states the access happens on the acceptance edge
    // itself, before the latch holds anything, so IDLE uses the live
    // request and every later state uses the latched copy.
    always_comb begin
        acc_idx   = lat_idx;
        acc_wea   = lat_wea;
        acc_wdata = lat_wdata;
        acc_err   = lat_err;
        if (state == ST_IDLE) begin
            acc_idx   = req_addr[ADDR_WIDTH+1:2];
            acc_wea   = req_wea;
            acc_wdata = req_wdata;
            acc_err   = req_err;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: begin
                if (req_en) begin
                    next_state = (WAIT_STATES > 0) ? ST_WAIT : ST_RESP;
                end
            end
            ST_WAIT: begin
                if (wait_cnt == 4'd1) begin
                    next_state = ST_RESP;
                end
            end
            ST_RESP: next_state = ST_IDLE;
            default: next_state = ST_IDLE;
        endcase
    end

    assign access_fire = (next_state == ST_RESP) && (state != ST_RESP);
    assign resp_valid  = (state == ST_RESP);
    assign stall_req   = ((state == ST_IDLE) && req_en) || (state == ST_WAIT);

    // rdata_live says whether the array output belongs to the most
    // recent completed access; reset and out-of-range accesses force
    // resp_rdata to zero without needing a reset on the array.
    assign resp_rdata = rdata_live ? arr_dout : '0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= ST_IDLE;
            wait_cnt   <= 4'd0;
            lat_idx    <= '0;
            lat_wea    <= '0;
            lat_wdata  <= '0;
            lat_err    <= 1'b0;
            resp_err   <= 1'b0;
            rdata_live <= 1'b0;
        end else begin
            state <= next_state;
            if ((state == ST_IDLE) && req_en) begin
                lat_idx   <= req_addr[ADDR_WIDTH+1:2];
                lat_wea   <= req_wea;
                lat_wdata <= req_wdata;
                lat_err   <= req_err;
                wait_cnt  <= 4'(WAIT_STATES);
            end else if (state == ST_WAIT) begin
                wait_cnt <= wait_cnt - 4'd1;
            end
            if (access_fire) begin
                resp_err   <= acc_err;
                rdata_live <= !acc_err;
            end
        end
    end

    dmem_array #(
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_array (
        .clk  (clk),
        .en   (access_fire && !acc_err),
        .wea  (acc_wea),
        .idx  (acc_idx),
        .din  (acc_wdata),
        .dout (arr_dout)
    );

endmodule
